// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I major opcodes, immediate formats, fetch and decode records
package riscv_pkg;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;
  function automatic imm_type_e imm_type(input logic [6:0] opc);
    return (opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_JALR) ? IMM_I :
           (opc == OPC_STORE)                                      ? IMM_S :
           (opc == OPC_BRANCH)                                     ? IMM_B :
           (opc == OPC_LUI || opc == OPC_AUIPC)                    ? IMM_U :
           (opc == OPC_JAL)                                        ? IMM_J : IMM_NONE;
  endfunction
endpackage

// File: rtl/instr_buf.sv
// instr_buf: 2-entry {pc, instr} FIFO with registered full flag
// Ports: clk_i/rstn_i clock and async active-low reset; push/pop/clear
// controls (clear wins over push and pop); wdata in, rdata head out;
// empty combinational, full registered (next count == DEPTH).
module instr_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  fetch_t wdata,
  output fetch_t rdata,
  output logic   empty,
  output logic   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  always_comb count_nxt = clear ? '0 : count + CW'(push) - CW'(pop);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count  <= '0;
      full   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count_nxt;
      full   <= count_nxt == CW'(DEPTH);
      wr_ptr <= clear ? '0 : wr_ptr + AW'(push);
      rd_ptr <= clear ? '0 : rd_ptr + AW'(pop);
    end
  end
  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
endmodule

// File: rtl/simple_decode.sv
// simple_decode: buffered RV32I decode stage with optional early JAL redirect
// Ports: clk_i/rstn_i clock and async active-low reset; valid_i/instr_i/pc_i
// fetch stream with stall_o registered backpressure; new_pc_o/pc_o fetch
// redirect; flush_i kill from execute; stall_i downstream backpressure;
// valid_o plus decoded fields of the buffer head (zero while empty).
// Macro DECODE_JAL_REDIRECT_EN enables the JAL redirect FSM and squash.
module simple_decode
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        stall_o,
  output logic        new_pc_o,
  output logic [31:0] pc_o,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] dec_pc_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] imm_o,
  output logic        illegal_o
);
  function automatic dec_t decode(input logic [31:0] i);
    dec_t      d;
    imm_type_e t;
    t = imm_type(i[6:0]);
    d.opcode  = i[6:0];
    d.rd      = i[11:7];
    d.funct3  = i[14:12];
    d.rs1     = i[19:15];
    d.rs2     = i[24:20];
    d.funct7  = i[31:25];
    d.imm     = t == IMM_I ? {{20{i[31]}}, i[31:20]} :
                t == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
                t == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                t == IMM_U ? {i[31:12], 12'h000} :
                t == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'h0;
    d.illegal = !(i[6:0] inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
                                 OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM});
    return d;
  endfunction
  fetch_t head;
  dec_t   dec;
  logic   empty, push, pop, clear, squash, jal_pop;
  assign valid_o = !empty;
  assign pop     = valid_o && !stall_i;
  assign push    = valid_i && !stall_o && !flush_i && !squash;
  assign clear   = flush_i || jal_pop;
  assign dec     = valid_o ? decode(head.instr) : '0;
  instr_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata ({pc_i, instr_i}),
    .rdata (head),
    .empty (empty),
    .full  (stall_o)
  );
`ifdef DECODE_JAL_REDIRECT_EN
  typedef enum logic {RUN, REDIRECT} state_e;
  state_e state, state_nxt;
  // A JAL leaving the buffer flushes the wrong-path entry behind it
  assign jal_pop = pop && !flush_i && dec.opcode == OPC_JAL;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RUN;
      pc_o  <= '0;
    end else begin
      state <= state_nxt;
      if (jal_pop) pc_o <= head.pc + dec.imm;
    end
  end
  always_comb begin
    state_nxt = jal_pop ? REDIRECT : RUN;
    squash    = state == REDIRECT;
    new_pc_o  = state == REDIRECT && !flush_i;
  end
`else
  assign jal_pop  = 1'b0;
  assign squash   = 1'b0;
  assign new_pc_o = 1'b0;
  assign pc_o     = '0;
`endif
  assign dec_pc_o  = valid_o ? head.pc : '0;
  assign opcode_o  = dec.opcode;
  assign rd_o      = dec.rd;
  assign rs1_o     = dec.rs1;
  assign rs2_o     = dec.rs2;
  assign funct3_o  = dec.funct3;
  assign funct7_o  = dec.funct7;
  assign imm_o     = dec.imm;
  assign illegal_o = dec.illegal;
endmodule
